// File: rtl/nested_scan_pkg.sv
// Shared types for the nested-loop scan controller: FSM states, address width
// and the latched job configuration.
package nested_scan_pkg;

  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] x_max;
    logic [ADDR_W-1:0] x_stride;
    logic [ADDR_W-1:0] y_max;
    logic [ADDR_W-1:0] y_stride_op;
  } scan_cfg_t;

endpackage

// File: rtl/nested_scan_core.sv
// Inner/outer index counters and strided accumulator; addr = offset + accumulator.
// clear wins over advance so a new pass can restart on the same cycle as a beat.
module nested_scan_core
  import nested_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  scan_cfg_t         cfg,
  output logic [ADDR_W-1:0] x_idx,
  output logic [ADDR_W-1:0] y_idx,
  output logic [ADDR_W-1:0] addr,
  output logic              at_last
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;
  logic              x_end, y_end;

  assign x_end   = (x_q == cfg.x_max - ONE);
  assign y_end   = (y_q == cfg.y_max - ONE);
  assign at_last = x_end & y_end;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    acc_d = acc_q;
    if (clear) begin
      x_d   = '0;
      y_d   = '0;
      acc_d = '0;
    end else if (advance) begin
      if (x_end) begin
        x_d   = '0;
        acc_d = acc_q + cfg.y_stride_op;
        // y holds on the final wrap; the controller leaves RUN or clears.
        if (!y_end) y_d = y_q + ONE;
      end else begin
        x_d   = x_q + ONE;
        acc_d = acc_q + cfg.x_stride;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      acc_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

  assign x_idx = x_q;
  assign y_idx = y_q;
  assign addr  = cfg.offset + acc_q;

endmodule

// File: rtl/nested_scan_ctrl.sv
// Scan job controller: start/busy/done handshake, config latch and valid/ready
// address stream. Define NESTED_SCAN_CTRL_REPEAT_EN to add multi-pass jobs (cfg_repeat).
module nested_scan_ctrl
  import nested_scan_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] cfg_offset,
  input  logic [W-1:0] cfg_x_max,
  input  logic [W-1:0] cfg_x_stride,
  input  logic [W-1:0] cfg_y_max,
  input  logic [W-1:0] cfg_y_stride_op,
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
  input  logic [W-1:0] cfg_repeat,
`endif
  output logic         busy,
  output logic         done,
  output logic         addr_valid,
  input  logic         addr_ready,
  output logic [W-1:0] addr_out,
  output logic         addr_last,
  output logic [W-1:0] x_idx,
  output logic [W-1:0] y_idx
);

  scan_state_e state_q, state_d;
  scan_cfg_t   cfg_q;
  logic        latch, clear, advance, at_last, final_pass;

`ifdef NESTED_SCAN_CTRL_REPEAT_EN
  logic [W-1:0] rep_q, rep_d;

  assign final_pass = (rep_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign final_pass = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    clear      = 1'b0;
    advance    = 1'b0;
    addr_valid = 1'b0;
    done       = 1'b0;
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
    rep_d      = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          clear   = 1'b1;
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
          rep_d   = cfg_repeat;
`endif
          // Extents come straight from the inputs: cfg_q is only loaded this edge.
          state_d = (cfg_x_max != '0 && cfg_y_max != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        addr_valid = 1'b1;
        advance    = addr_ready;
        if (abort) begin
          state_d = IDLE;
        end else if (addr_ready && at_last) begin
          if (final_pass) begin
            state_d = DONE;
          end else begin
            clear = 1'b1;
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
            rep_d = rep_q - W'(1);
`endif
          end
        end
      end
      DONE: begin
        done    = ~abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cfg_q.offset      <= cfg_offset;
        cfg_q.x_max       <= cfg_x_max;
        cfg_q.x_stride    <= cfg_x_stride;
        cfg_q.y_max       <= cfg_y_max;
        cfg_q.y_stride_op <= cfg_y_stride_op;
      end
    end
  end

  nested_scan_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .cfg     (cfg_q),
    .x_idx   (x_idx),
    .y_idx   (y_idx),
    .addr    (addr_out),
    .at_last (at_last)
  );

  assign busy      = (state_q != IDLE);
  assign addr_last = addr_valid & at_last & final_pass;

endmodule

// File: tb/tb_nested_scan_ctrl.sv
// Randomized self-checking bench for nested_scan_ctrl against a closed-form
// address model; repeat scenarios compile in when NESTED_SCAN_CTRL_REPEAT_EN is set.
module tb_nested_scan_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, addr_ready = 1'b0;
  logic [W-1:0] cfg_offset = '0, cfg_x_max = '0, cfg_x_stride = '0;
  logic [W-1:0] cfg_y_max = '0, cfg_y_stride_op = '0;
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
  logic [W-1:0] cfg_repeat = '0;
`endif
  logic         busy, done, addr_valid, addr_last;
  logic [W-1:0] addr_out, x_idx, y_idx;

  int checks = 0;
  int errors = 0;

  nested_scan_ctrl #(.W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_offset      (cfg_offset),
    .cfg_x_max       (cfg_x_max),
    .cfg_x_stride    (cfg_x_stride),
    .cfg_y_max       (cfg_y_max),
    .cfg_y_stride_op (cfg_y_stride_op),
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
    .cfg_repeat      (cfg_repeat),
`endif
    .busy            (busy),
    .done            (done),
    .addr_valid      (addr_valid),
    .addr_ready      (addr_ready),
    .addr_out        (addr_out),
    .addr_last       (addr_last),
    .x_idx           (x_idx),
    .y_idx           (y_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [W-1:0] o, xm, xs, ym, ys);
    cfg_offset = o; cfg_x_max = xm; cfg_x_stride = xs;
    cfg_y_max = ym; cfg_y_stride_op = ys;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, addr_valid, addr_last} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, addr_valid, addr_last});
    end
    checks++;
    if ({addr_out, x_idx, y_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h x=%h y=%h expected all 0", addr_out, x_idx, y_idx);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // noise: keep poking start and cfg_* mid-job; none of it may take effect.
  task automatic test_scan(input string name, input logic [W-1:0] o, xm, xs, ym, ys,
                           input int rmode, input int rep, input bit noise);
    logic [W-1:0] exp_a[$], exp_x[$], exp_y[$];
    logic [W-1:0] pa, px, py;
    bit           stalled;
    int           n, cyc, total;
    for (int p = 0; p <= rep; p++)
      for (int y = 0; y < int'(ym); y++)
        for (int x = 0; x < int'(xm); x++) begin
          logic [W-1:0] a;
          a = o + W'(y) * ((xm - W'(1)) * xs + ys) + W'(x) * xs;
          exp_a.push_back(a);
          exp_x.push_back(W'(x));
          exp_y.push_back(W'(y));
        end
    total = exp_a.size();
    set_cfg(o, xm, xs, ym, ys);
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
    cfg_repeat = W'(rep);
`endif
    addr_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    if (total == 0) begin
      checks++;
      if (addr_valid !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL %s zero_job: got valid=%b done=%b expected valid=0 done=1", name, addr_valid, done);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL %s zero_end: got busy=%b done=%b expected 0 0", name, busy, done);
      end
      return;
    end
    n = 0; cyc = 0; stalled = 1'b0; pa = '0; px = '0; py = '0;
    while (n < total && cyc < 400) begin
      case (rmode)
        0:       addr_ready = 1'b1;
        1:       addr_ready = (cyc % 3 == 0);
        default: addr_ready = 1'($urandom_range(0, 1));
      endcase
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        set_cfg(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      end
      checks++;
      if (addr_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s valid beat %0d: got valid=%b done=%b expected 1 0", name, n, addr_valid, done);
      end
      checks++;
      if (addr_out !== exp_a[n] || x_idx !== exp_x[n] || y_idx !== exp_y[n]) begin
        errors++;
        $display("FAIL %s beat %0d: got addr=%h x=%0d y=%0d expected addr=%h x=%0d y=%0d",
                 name, n, addr_out, x_idx, y_idx, exp_a[n], exp_x[n], exp_y[n]);
      end
      checks++;
      if (addr_last !== (n == total - 1)) begin
        errors++;
        $display("FAIL %s last beat %0d: got %b expected %b", name, n, addr_last, (n == total - 1));
      end
      if (stalled) begin
        checks++;
        if (addr_out !== pa || x_idx !== px || y_idx !== py) begin
          errors++;
          $display("FAIL %s stall_hold: got %h/%0d/%0d expected %h/%0d/%0d",
                   name, addr_out, x_idx, y_idx, pa, px, py);
        end
      end
      stalled = !addr_ready; pa = addr_out; px = x_idx; py = y_idx;
      if (addr_ready) n++;
      tick();
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    checks++;
    if (n < total) begin
      errors++; $display("FAIL %s timeout: got %0d beats expected %0d", name, n, total);
    end
    checks++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%b valid=%b busy=%b expected 1 0 1", name, done, addr_valid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_done: got busy=%b done=%b expected 0 0", name, busy, done);
    end
  endtask

  task automatic test_abort();
    set_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd6);
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
    cfg_repeat = '0;
`endif
    addr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (addr_out !== 16'd104) begin
      errors++; $display("FAIL abort_pos: got %0d expected 104", addr_out);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    addr_ready = 1'b0;
    checks++;
    if (addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_mid: got valid=%b done=%b busy=%b expected 0 0 0", addr_valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got %b expected 0", done);
    end
    test_scan("after_abort", 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 0, 0, 1'b0);
    // Abort landing on the final handshake: the beat is gone but done never fires.
    set_cfg(16'd7, 16'd1, 16'd0, 16'd1, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (addr_last !== 1'b1 || addr_out !== 16'd7) begin
      errors++; $display("FAIL abort_last_pre: got last=%b addr=%0d expected 1 7", addr_last, addr_out);
    end
    abort = 1'b1;
    addr_ready = 1'b1;
    tick();
    abort = 1'b0;
    addr_ready = 1'b0;
    checks++;
    if (done !== 1'b0 || addr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_last: got done=%b valid=%b busy=%b expected 0 0 0", done, addr_valid, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    set_cfg(16'd100, 16'd3, 16'd2, 16'd2, 16'd6);
    addr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, addr_valid, addr_last, addr_out, x_idx, y_idx} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b valid=%b addr=%h x=%0d y=%0d expected all 0",
               busy, addr_valid, addr_out, x_idx, y_idx);
    end
    #2;
    rst_n = 1'b1;
    addr_ready = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int rep;
      rep = 0;
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
      rep = $urandom_range(0, 2);
`endif
      test_scan("random", W'($urandom), W'($urandom_range(0, 4)), W'($urandom),
                W'($urandom_range(0, 4)), W'($urandom), 2, rep, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_scan("normal", 16'd100, 16'd3, 16'd2, 16'd2, 16'd6, 0, 0, 1'b0);
    test_scan("backpressure", 16'd100, 16'd3, 16'd2, 16'd2, 16'd6, 1, 0, 1'b0);
    test_scan("zero_extent", 16'd100, 16'd0, 16'd2, 16'd5, 16'd6, 0, 0, 1'b0);
    test_abort();
    test_reset_mid_run();
    test_scan("wrap", 16'hFFFE, 16'd2, 16'd3, 16'd1, 16'd0, 0, 0, 1'b0);
`ifdef NESTED_SCAN_CTRL_REPEAT_EN
    test_scan("repeat", 16'd100, 16'd3, 16'd2, 16'd2, 16'd6, 0, 1, 1'b0);
    test_scan("repeat_zero", 16'd100, 16'd3, 16'd2, 16'd0, 16'd6, 0, 2, 1'b0);
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
